// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Constants and types shared by the P7 pipeline stages (F/D/E/M) and CP0.
//   npc_sel_e   : next-PC source encoding carried from D to F
//   EXC_*       : CP0 ExcCode values
//   PC_RESET    : PC after reset
//   EXC_ENTRY   : exception/interrupt handler entry
//   IM_BASE/TOP : legal instruction-fetch window (inclusive)
//   word_addr_ok: alignment plus window check reused by F and M stages
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_TOP    = 32'h0000_6ffc;

  // True when addr is word aligned and lies inside [lo, hi].
  function automatic logic word_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/f_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl_if
// Bundle between the fetch controller and the rest of the pipeline.
//   D-side control : F_WE, D_npc_sel, D_*_target, D_is_jump, D_eret
//   CP0            : req, EPC_in
//   Instr memory   : IM_addr (out), IM_instr (in, combinational read)
//   F bundle       : F_command, F_PC, F_EPC, F_exc, F_BD (to D register)
// master = fetch controller, slave = surrounding pipeline / bench.
// ---------------------------------------------------------------------------
interface f_fetch_ctrl_if;

  logic        F_WE;
  logic [1:0]  D_npc_sel;
  logic [31:0] D_br_target;
  logic [31:0] D_j_target;
  logic [31:0] D_jr_target;
  logic        D_is_jump;
  logic        D_eret;
  logic        req;
  logic [31:0] EPC_in;
  logic [31:0] IM_instr;

  logic [31:0] IM_addr;
  logic [31:0] F_command;
  logic [31:0] F_PC;
  logic [31:0] F_EPC;
  logic [4:0]  F_exc;
  logic        F_BD;

  modport master (
    input  F_WE, D_npc_sel, D_br_target, D_j_target, D_jr_target,
           D_is_jump, D_eret, req, EPC_in, IM_instr,
    output IM_addr, F_command, F_PC, F_EPC, F_exc, F_BD
  );

  modport slave (
    output F_WE, D_npc_sel, D_br_target, D_j_target, D_jr_target,
           D_is_jump, D_eret, req, EPC_in, IM_instr,
    input  IM_addr, F_command, F_PC, F_EPC, F_exc, F_BD
  );

endinterface

// File: rtl/f_fetch_ctrl_adel.sv
// ---------------------------------------------------------------------------
// f_adel_check
// Combinational address-error check for an instruction fetch.
//   pc_i    : fetch address
//   fault_o : 1 when pc_i is misaligned or outside [BASE, TOP]
// The M stage instantiates the same pattern for data AdEL/AdES.
// ---------------------------------------------------------------------------
module f_adel_check
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE = mips_pkg::IM_BASE,
  parameter logic [31:0] TOP  = mips_pkg::IM_TOP
) (
  input  logic [31:0] pc_i,
  output logic        fault_o
);

  assign fault_o = !word_addr_ok(pc_i, BASE, TOP);

endmodule

// File: rtl/f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl
// F-stage fetch controller of the P7 pipeline. Owns the PC, drives the
// instruction-memory address and builds the F bundle latched by D.
//   clk : clock
//   res : synchronous active-high reset
//   bus : f_fetch_ctrl_if.master
//         inputs  F_WE, D_npc_sel, D_br/j/jr_target, D_is_jump, D_eret,
//                 req, EPC_in, IM_instr
//         outputs IM_addr, F_command, F_PC, F_EPC, F_exc, F_BD
// Next-PC priority: res > req > D_eret > stall (F_WE=0) > D_npc_sel > PC+4.
// ---------------------------------------------------------------------------
module f_fetch_ctrl #(
  parameter logic [31:0] PC_RESET  = mips_pkg::PC_RESET,
  parameter logic [31:0] EXC_ENTRY = mips_pkg::EXC_ENTRY,
  parameter logic [31:0] IM_BASE   = mips_pkg::IM_BASE,
  parameter logic [31:0] IM_TOP    = mips_pkg::IM_TOP,
  parameter logic [4:0]  EXC_ADEL  = mips_pkg::EXC_ADEL
) (
  input  logic          clk,
  input  logic          res,
  f_fetch_ctrl_if.master bus
);

  import mips_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fetchFault;
  logic        killFetch;
  npc_sel_e    npcSel;

  assign npcSel = npc_sel_e'(bus.D_npc_sel);

  // Redirects from CP0 (req, eret) bypass the hazard stall: the pipeline
  // is being flushed, so holding the PC would fetch from a dead stream.
  always_comb begin
    pc_d = pc_q;
    if (bus.req) begin
      pc_d = EXC_ENTRY;
    end else if (bus.D_eret) begin
      pc_d = bus.EPC_in;
    end else if (bus.F_WE) begin
      unique case (npcSel)
        NPC_BR:  pc_d = bus.D_br_target;
        NPC_J:   pc_d = bus.D_j_target;
        NPC_JR:  pc_d = bus.D_jr_target;
        default: pc_d = pc_q + 32'd4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  f_adel_check #(
    .BASE (IM_BASE),
    .TOP  (IM_TOP)
  ) u_adel (
    .pc_i    (pc_q),
    .fault_o (fetchFault)
  );

  // The sequential fetch sitting behind an eret in D is discarded, so it
  // must neither carry an instruction nor report an address error.
  assign killFetch = bus.D_eret;

  assign bus.IM_addr   = pc_q;
  assign bus.F_PC      = pc_q;
  assign bus.F_BD      = bus.D_is_jump;
  assign bus.F_EPC     = bus.D_is_jump ? (pc_q - 32'd4) : pc_q;
  assign bus.F_command = (killFetch || fetchFault) ? 32'h0 : bus.IM_instr;
  assign bus.F_exc     = killFetch  ? EXC_NONE :
                         fetchFault ? EXC_ADEL : EXC_NONE;

endmodule
